issue_dispatch_unit: RTL
========================

// Module: issue_dispatch_unit
// PURPOSE
//  Parametrised front end of the Tomasulo issue stage. Buffers fetched instructions in an
//  in-order queue, decodes the head and dispatches it to one of NUM_RS reservation-station
//  classes. Dispatch stalls while the target class reports full.
//  Supersedes the combinational decoder: adds buffering, registered issue, flush,
//  illegal-op drop and a stall counter.
// PARAMETERS
//  NUM_RS      3   reservation-station classes (0 addsub, 1 mul, 2 div); legal values 1..8
//  QUEUE_DEPTH 4   instruction-queue entries; power of two, >= 2
//  INSTR_W     32  instruction width; op = [31:26], func = [5:0]
//  SEL_W       $clog2(NUM_RS) (min 1) width of ALUSel
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  instrIn      in   INSTR_W  fetched instruction
//  instrValid   in   1        instrIn valid this cycle
//  instrReady   out  1        queue can accept (count < QUEUE_DEPTH)
//  flush        in   1        discard queue and pending issue (mispredict/exception)
//  isFull       in   NUM_RS   per-class reservation station full
//  issueValid   out  1        issue fields valid this cycle (one-cycle pulse per instr)
//  issueInstr   out  INSTR_W  issued instruction word
//  ALUop        out  2        0 add, 1 sub, 2 and, 3 or
//  ALUSel       out  SEL_W    target class index
//  ResStationEN out  NUM_RS   one-hot write enable of target class; 0 when not issuing
//  RegDst       out  1        1 = rd (R-format), 0 = rt
//  vkSrc        out  1        1 = rt data (R-format), 0 = immediate
//  illegal      out  1        one-cycle pulse: head instruction was unsupported and dropped
//  stallCount   out  16       cycles the head was blocked by isFull; saturating
// BEHAVIOUR
//  Reset: queue empty, all pointers 0, FSM EMPTY, every output 0 except instrReady = 1.
//  Decode (MIPS encodings): op 0x00 with func ADD 0x20 -> add, SUB 0x22 -> sub, AND 0x24 -> and,
//   OR 0x25 -> or (all class 0); MULU 0x19 -> add, class 1; DIVU 0x1B -> add, class 2.
//   ADDI 0x08 -> add, ORI 0x0D -> or, class 0. Anything else, or a class >= NUM_RS, is illegal.
//   RegDst = vkSrc = (op == 0).
//  Push: instrValid & instrReady & ~flush writes the tail at the edge. There is no bypass:
//   a full queue deasserts instrReady even if the head pops in the same cycle.
//  Pop/dispatch (head valid, ~flush): legal & ~isFull[class] pops and loads the issue
//   registers; illegal pops and pulses illegal; blocked holds the head and increments
//   stallCount (stops at 0xFFFF).
//  Issue outputs are registered. An accept at edge k can issue at edge k+1 at the earliest.
//   Sustained throughput is 1 per cycle. issueValid and ResStationEN return to 0 in any
//   cycle without a dispatch; the other fields hold their last values.
//  Simultaneous push and pop: count unchanged, both pointers advance, wrap mod QUEUE_DEPTH.
//  Flush (synchronous, highest priority): at the edge, count = 0, pointers = 0,
//   issueValid/ResStationEN/illegal = 0. Same-cycle push and dispatch are discarded;
//   stallCount is kept.
//  FSM (registered): EMPTY (count 0) -> RUN on push. RUN -> STALL when head blocked.
//   STALL -> RUN when isFull clears. RUN/STALL -> EMPTY when the last entry pops or on flush.
//  isFull is sampled only in the dispatch cycle. A class going full after issue does not
//   retract that issue.
//  Reset asserted mid-operation returns to the reset state immediately, no completion.
// TESTING
//  1 push ADD (op0,func0x20), isFull=0 -> next cycle issueValid=1, ResStationEN=001,
//    ALUop=0, RegDst=1, vkSrc=1.
//  2 push MULU, DIVU, ORI back-to-back -> ResStationEN 010, 100, 001 on consecutive
//    cycles; ORI: ALUop=3, RegDst=0, vkSrc=0.
//  3 push 5 with isFull=111 (DEPTH 4) -> instrReady=0 after 4 accepted, 5th held by source;
//    stallCount increments each cycle; clear isFull -> 4 issues in order, then the 5th.
//  4 push op 0x23 -> illegal pulses 1 cycle, ResStationEN=0, next entry issues following cycle.
//  5 queue of 3, flush with instrValid=1 -> next cycle count 0, issueValid=0, instrReady=1,
//    flushed push absent.
//  6 rst pulse mid-stall, asynchronous to clk -> all outputs 0 (instrReady=1, stallCount=0)
//    before the next edge.

Source files
------------

// File: rtl/issue_dispatch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : issue_dispatch_unit
//  Description : Tomasulo issue front end. An in-order instruction queue feeds
//                a decoder. The decoder dispatches the head instruction to one
//                of NUM_RS reservation-station classes, drops unsupported ops,
//                and counts cycles blocked by a full station.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_dispatch_unit #(
    parameter int NUM_RS      = 3,
    parameter int QUEUE_DEPTH = 4,
    parameter int INSTR_W     = 32,
    parameter int SEL_W       = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instrIn,
    input  logic                instrValid,
    output logic                instrReady,
    input  logic                flush,
    input  logic [NUM_RS-1:0]   isFull,
    output logic                issueValid,
    output logic [INSTR_W-1:0]  issueInstr,
    output logic [1:0]          ALUop,
    output logic [SEL_W-1:0]    ALUSel,
    output logic [NUM_RS-1:0]   ResStationEN,
    output logic                RegDst,
    output logic                vkSrc,
    output logic                illegal,
    output logic [15:0]         stallCount
);
    localparam int               c_PTR_W  = $clog2(QUEUE_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH  = (c_PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [3:0]       c_NUM_RS = 4'(NUM_RS);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    logic [INSTR_W-1:0] r_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_next;
    state_t             r_state;
    state_t             w_state_next;

    logic               r_issue_valid;
    logic [INSTR_W-1:0] r_issue_instr;
    logic [1:0]         r_aluop;
    logic [SEL_W-1:0]   r_alusel;
    logic [NUM_RS-1:0]  r_rsen;
    logic               r_regdst;
    logic               r_vksrc;
    logic               r_illegal;
    logic [15:0]        r_stall;

    logic [INSTR_W-1:0] w_head;
    logic [5:0]         w_op;
    logic [5:0]         w_func;
    logic               w_known;
    logic               w_legal;
    logic [2:0]         w_cls;
    logic [1:0]         w_aluop;
    logic [NUM_RS-1:0]  w_onehot;
    logic               w_target_full;
    logic               w_head_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_dispatch;
    logic               w_drop;
    logic               w_blocked;

    assign w_head       = r_mem[r_head];
    assign w_op         = w_head[31:26];
    assign w_func       = w_head[5:0];
    assign w_head_valid = (r_count != '0);
    // No bypass: a full queue refuses input even when the head leaves this cycle.
    assign instrReady   = (r_count < c_DEPTH);

    // Decode the head instruction into class and ALU operation.
    always_comb begin
        w_known = 1'b1;
        w_cls   = 3'd0;
        w_aluop = 2'd0;
        if (w_op == 6'h00) begin
            case (w_func)
                6'h20:   w_aluop = 2'd0;
                6'h22:   w_aluop = 2'd1;
                6'h24:   w_aluop = 2'd2;
                6'h25:   w_aluop = 2'd3;
                6'h19:   w_cls   = 3'd1;
                6'h1B:   w_cls   = 3'd2;
                default: w_known = 1'b0;
            endcase
        end else if (w_op == 6'h08) begin
            w_aluop = 2'd0;
        end else if (w_op == 6'h0D) begin
            w_aluop = 2'd3;
        end else begin
            w_known = 1'b0;
        end
    end

    // Select the full flag and write-enable bit of the decoded class.
    always_comb begin
        w_target_full = 1'b0;
        w_onehot      = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if ({1'b0, w_cls} == 4'(i)) begin
                w_target_full = isFull[i];
                w_onehot[i]   = 1'b1;
            end
        end
    end

    // A class index beyond the configured stations is treated as unsupported.
    assign w_legal    = w_known & ({1'b0, w_cls} < c_NUM_RS);
    assign w_dispatch = w_head_valid & ~flush & w_legal & ~w_target_full;
    assign w_drop     = w_head_valid & ~flush & ~w_legal;
    assign w_blocked  = w_head_valid & ~flush & w_legal & w_target_full;
    assign w_pop      = w_dispatch | w_drop;
    assign w_push     = instrValid & instrReady & ~flush;

    // Next occupancy; flush empties the queue outright.
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Queue-state tracking: empty, running, or blocked on a full station.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_push)     w_state_next = S_RUN;
            S_RUN:   if (w_blocked)  w_state_next = S_STALL;
            S_STALL: if (!w_blocked) w_state_next = S_RUN;
            default:                 w_state_next = S_EMPTY;
        endcase
        if (flush || (w_count_next == '0)) begin
            w_state_next = S_EMPTY;
        end
    end

    // Queue storage is written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= instrIn;
        end
    end

    // Pointers, occupancy and state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_EMPTY;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
            if (flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_pop)  r_head <= r_head + 1'b1;
                if (w_push) r_tail <= r_tail + 1'b1;
            end
        end
    end

    // Registered issue fields; valid/enable/illegal pulse, the rest hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_aluop       <= '0;
            r_alusel      <= '0;
            r_rsen        <= '0;
            r_regdst      <= 1'b0;
            r_vksrc       <= 1'b0;
            r_illegal     <= 1'b0;
            r_stall       <= '0;
        end else begin
            r_issue_valid <= w_dispatch;
            r_rsen        <= w_dispatch ? w_onehot : '0;
            r_illegal     <= w_drop;
            if (w_dispatch) begin
                r_issue_instr <= w_head;
                r_aluop       <= w_aluop;
                r_alusel      <= w_cls[SEL_W-1:0];
                r_regdst      <= (w_op == 6'h00);
                r_vksrc       <= (w_op == 6'h00);
            end
            if (w_blocked && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign issueValid   = r_issue_valid;
    assign issueInstr   = r_issue_instr;
    assign ALUop        = r_aluop;
    assign ALUSel       = r_alusel;
    assign ResStationEN = r_rsen;
    assign RegDst       = r_regdst;
    assign vkSrc        = r_vksrc;
    assign illegal      = r_illegal;
    assign stallCount   = r_stall;

endmodule
`default_nettype wire
